// File: rtl/fre_count_latch_pkg.sv
// Shared decade constants and defaults for the frequency-meter measurement stage.
// The gate controller and the display driver import the same package.
package fre_count_latch_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  localparam int DEFAULT_DIGITS      = 6;
  localparam int DEFAULT_SYNC_STAGES = 2;

  function automatic logic bcd_is_max(input logic [3:0] d);
    return d == BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the measurement counter: clears or steps 0..9, carries on 9 -> 0.
// Registered count, combinational carry; no backpressure.
module bcd_digit
  import fre_count_latch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc & bcd_is_max(q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BCD_ZERO;
    end else if (clr) begin
      q <= BCD_ZERO;
    end else if (inc) begin
      q <= bcd_is_max(q) ? BCD_ZERO : q + 4'd1;
    end
  end

endmodule

// File: rtl/fre_count_latch.sv
// Counts synchronised rising edges of sig_in inside the gate window and latches the BCD result on load.
// sig_in rise reaches the counter SYNC_STAGES+1 clk later; latch updates one clk after load rises; no backpressure.
module fre_count_latch
  import fre_count_latch_pkg::*;
#(
  parameter int DIGITS      = DEFAULT_DIGITS,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig_in,
  input  logic                  count_en,
  input  logic                  count_clr,
  input  logic                  load,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  overflow,
  output logic                  valid
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;

  logic [4*DIGITS-1:0]    count;
  logic [DIGITS-1:0]      dig_inc;
  logic [DIGITS-1:0]      dig_carry;
  logic [DIGITS-1:0]      dig_nine;
  logic                   all_nines;
  logic                   inc_req;
  logic                   ovf_cnt;
  logic                   ovf_set;

  logic                   load_d;
  logic                   ld_pulse;

  // Synchroniser chain followed by a single-flop rise detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  assign inc_req   = rise & count_en & ~count_clr;
  assign all_nines = &dig_nine;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      assign dig_nine[k] = bcd_is_max(count[4*k +: 4]);

      if (k == 0) begin : g_lsd
        // Saturation: the LSD is never stepped once every decade reads 9.
        assign dig_inc[k] = inc_req & ~all_nines;
      end else begin : g_upper
        assign dig_inc[k] = dig_carry[k-1];
      end

      bcd_digit u_digit (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (count_clr),
        .inc   (dig_inc[k]),
        .q     (count[4*k +: 4]),
        .carry (dig_carry[k])
      );
    end
  endgenerate

  // The MSD carry stays low while saturation gating holds; it is folded in so a wrap could never go unflagged.
  assign ovf_set = (inc_req & all_nines) | dig_carry[DIGITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 1'b0;
    end else if (count_clr) begin
      ovf_cnt <= 1'b0;
    end else if (ovf_set) begin
      ovf_cnt <= 1'b1;
    end
  end

  assign ld_pulse = load & ~load_d;

  // Latch samples the pre-update counter, so a coincident clear or increment is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_d   <= 1'b0;
      disp_bcd <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      load_d <= load;
      valid  <= ld_pulse;
      if (ld_pulse) begin
        disp_bcd <= count;
        overflow <= ovf_cnt;
      end
    end
  end

endmodule
